// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] data1,
  output logic              busy1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data2,
  output logic              busy2,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] data3,
  input  logic              iss,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic w_z1;
  logic w_z2;
  logic w_z3;
  logic w_zi;
  logic w_wr_ok;
  logic w_iss_ok;

  assign w_z1 = (ZERO_REG != 0) && (addr1 == '0);
  assign w_z2 = (ZERO_REG != 0) && (addr2 == '0);
  assign w_z3 = (ZERO_REG != 0) && (addr3 == '0);
  assign w_zi = (ZERO_REG != 0) && (iss_addr == '0);

  assign w_wr_ok  = wr && !w_z3;
  assign w_iss_ok = iss && !w_zi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[addr3] <= data3;
      end
      // a new producer on the same register outranks the retiring one
      if (flush) begin
        r_busy <= '0;
      end else begin
        if (w_wr_ok) begin
          r_busy[addr3] <= 1'b0;
        end
        if (w_iss_ok) begin
          r_busy[iss_addr] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    data1 = '0;
    busy1 = 1'b0;
    data2 = '0;
    busy2 = 1'b0;
    if (reset) begin
      if (!w_z1) begin
        data1 = r_mem[addr1];
        busy1 = r_busy[addr1];
      end
      if (!w_z2) begin
        data2 = r_mem[addr2];
        busy2 = r_busy[addr2];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (addr1 == addr3)) begin
        data1 = data3;
        busy1 = 1'b0;
      end
      if (w_wr_ok && (addr2 == addr3)) begin
        data2 = data3;
        busy2 = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random + directed stimulus against an array model,
// expectations queued and checked by an independent monitor.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  addr1 = '0;
  logic [31:0] data1;
  logic        busy1;
  logic [4:0]  addr2 = '0;
  logic [31:0] data2;
  logic        busy2;
  logic        wr = 1'b0;
  logic [4:0]  addr3 = '0;
  logic [31:0] data3 = '0;
  logic        iss = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       nm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_mem [32];
  logic        m_busy [32];

  regfile_sb dut (
    .clk      (clk),
    .reset    (reset),
    .addr1    (addr1),
    .data1    (data1),
    .busy1    (busy1),
    .addr2    (addr2),
    .data2    (data2),
    .busy2    (busy2),
    .wr       (wr),
    .addr3    (addr3),
    .data3    (data3),
    .iss      (iss),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  // reference model: register 0 is the hardwired zero register
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (wr && addr3 != 0) m_mem[addr3] <= data3;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end else begin
        if (iss && iss_addr != 0) m_busy[iss_addr] <= 1'b1;
        if (wr && addr3 != 0 && !(iss && iss_addr == addr3))
          m_busy[addr3] <= 1'b0;
      end
    end
  end

  function automatic void model_rd(input logic [4:0] a,
                                   output logic [31:0] d,
                                   output logic b);
    d = '0;
    b = 1'b0;
    if (reset === 1'b1 && a != 0) begin
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr && addr3 == a) begin
        d = data3;
        b = 1'b0;
      end
`endif
    end
  endfunction

  task automatic push(input string nm);
    exp_t e;
    e.nm = nm;
    model_rd(addr1, e.d1, e.b1);
    model_rd(addr2, e.d2, e.b2);
    q.push_back(e);
  endtask

  task automatic step(input string nm,
                      input logic w, input logic [4:0] a3,
                      input logic [31:0] d3,
                      input logic is, input logic [4:0] ia,
                      input logic fl,
                      input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    wr = w; addr3 = a3; data3 = d3;
    iss = is; iss_addr = ia; flush = fl;
    addr1 = a1; addr2 = a2;
    push(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".data1"}, data1, e.d1);
        chk({e.nm, ".data2"}, data2, e.d2);
        chk({e.nm, ".busy1"}, {31'd0, busy1}, {31'd0, e.b1});
        chk({e.nm, ".busy2"}, {31'd0, busy2}, {31'd0, e.b2});
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    // reset held with garbage on every input
    for (int i = 0; i < 3; i++) begin
      step("rst_hold", 1'b1, 5'($urandom), $urandom, 1'b1,
           5'($urandom), 1'b0, 5'($urandom), 5'($urandom));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr = 1'b1; addr3 = 5'd0; data3 = 32'hDEADBEEF;
    iss = 1'b0; flush = 1'b0; addr1 = 5'd0; addr2 = 5'd0;
    push("zero_wr");
    step("zero_rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    step("zero_rd2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    step("wr5", 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    step("rd5", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    step("iss7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd5);
    step("busy7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    step("wb7", 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    step("done7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5);
    step("coll9", 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 1'b0, 5'd9, 5'd7);
    step("coll9_rd", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
    step("iss3", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd9);
    step("iss4", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
    step("iss5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd4, 5'd5);
    step("flush", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd3, 5'd5);
    step("post_fl_a", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
    step("post_fl_b", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
    step("iss11", 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd5, 5'd9);
    step("pre_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd11);
    // async reset between edges with a write pending to r12
    @(posedge clk);
    #1;
    wr = 1'b1; addr3 = 5'd12; data3 = 32'h0BADC0DE;
    iss = 1'b1; iss_addr = 5'd13; flush = 1'b0;
    addr1 = 5'd5; addr2 = 5'd11;
    #1;
    reset = 1'b0;
    #1;
    push("rst_mid");
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr = 1'b0; iss = 1'b0;
    addr1 = 5'd12; addr2 = 5'd13;
    push("rst_lost");
    step("rst_after", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd5);
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/one-write register file for the pipelined core, with a per-register busy scoreboard and optional write-to-read bypass. It sits in the decode stage.
- Decode reads operands and their busy flags.
- Issue marks destination registers busy.
- Writeback stores results and clears the busy flags.
- A pipeline flush clears every busy flag without disturbing register contents.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- addr1  in  ADDR_W  read port 1 address
- data1  out  DATA_W  read port 1 data
- busy1  out  1  busy flag of addr1
- addr2  in  ADDR_W  read port 2 address
- data2  out  DATA_W  read port 2 data
- busy2  out  1  busy flag of addr2
- wr  in  1  writeback enable
- addr3  in  ADDR_W  writeback address
- data3  in  DATA_W  writeback data
- iss  in  1  issue strobe; marks iss_addr busy
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- flush  in  1  clear all busy flags

## Operation
State:
- mem[0 .. 2**ADDR_W-1] of DATA_W bits.
- busy[0 .. 2**ADDR_W-1] of 1 bit each.

Reset:
- reset low clears all mem and busy bits immediately, independent of clk.
- Consequently data1/data2 = 0 and busy1/busy2 = 0 while reset is low.

Write:
- At a rising edge with wr=1 and the address not the zero register, mem[addr3] <= data3.
- The zero register is addr3 = 0 with ZERO_REG = 1. Writes to it are silently dropped.

Busy update at each rising edge, in priority order:
- flush=1: every busy bit cleared. A concurrent iss is discarded. A concurrent wr still updates mem.
- Otherwise, iss=1 and iss_addr is not the zero register: busy[iss_addr] <= 1.
- Otherwise, wr=1 and addr3 is not the zero register: busy[addr3] <= 0.
- iss and wr to the same address in the same cycle: busy ends at 1, because the new producer wins. mem is still written.
- iss and wr to different addresses in the same cycle are independent.

Reads are combinational:
- Zero register: dataN = 0 and busyN = 0.
- Otherwise: dataN = mem[addrN] and busyN = busy[addrN], unless the bypass below applies.
- Both ports may read the same address simultaneously.

## Timing
- Read latency: 0 cycles (combinational from addrN and state).
- A write is visible on the read ports after the rising edge that performs it. With REGFILE_BYPASS_EN it is also visible in the same cycle.
- A busy flag set by iss is visible the cycle after the issuing edge. There is no same-cycle busy bypass from iss.
- A busy flag cleared by wr is visible after the edge. With REGFILE_BYPASS_EN it is also cleared in the same cycle.
- A flush is visible after the edge.
- Reset deassertion: the first state update occurs at the first rising edge with reset high.
- Reset asserted mid-operation: pending writes, issues and flushes in that cycle are lost; all state is zero.

## Configuration
REGFILE_BYPASS_EN
- Defined: a read port whose address matches a write under way this cycle returns the write data and reports not-busy.
  - The write counts as under way when wr=1, addrN = addr3 and the address is not the zero register.
  - The port returns dataN = data3 and busyN = 0, unless flush/iss rules leave the bit set after the edge. Only the current-cycle output is bypassed.
- Undefined: no bypass. Reads return stored mem/busy only, and a write is seen one cycle later.

## Test plan
- Reset and zero register:
  - Hold reset low with garbage on all inputs: data1 = data2 = 0 and busy1 = busy2 = 0.
  - Release reset, then wr=1, addr3=0, data3=32'hDEADBEEF: addr1=0 reads 0 and busy1 = 0 on every following cycle.
- Basic write/read: wr to addr3=5 with 32'h12345678 at edge N, addr1=addr2=5.
  - Bypass defined: reads 32'h12345678 in cycle N.
  - Bypass undefined: reads the old value 0 in cycle N and 32'h12345678 from cycle N+1.
- Scoreboard: iss with iss_addr=7 at edge N; busy1 = 1 for addr1=7 from cycle N+1. Then wr to addr3=7 at edge M: busy1 = 0 from cycle M+1 (from cycle M with bypass), and data1 = data3.
- Collision: iss_addr=9 and wr with addr3=9, data3=32'hA5A5A5A5 in the same cycle: after the edge busy[9] = 1 and mem[9] = 32'hA5A5A5A5.
- Flush: make registers 3, 4 and 5 busy, then flush=1 with iss_addr=6 in the same cycle: after the edge busy[3..6] are all 0 and mem is unchanged.
- Async reset mid-operation: pulse reset low between edges while registers hold data and busy bits: all outputs go to 0 immediately, with no clock edge required. A wr pending in that cycle does not land.
